spi_cmd_ram: RTL and testbench
==============================

# spi_cmd_ram

Parametrised command-decoding RAM that sits behind the SPI slave's receive/transmit word interface. It accepts 2-bit-opcode command words from the SPI slave, keeps independent write and read address pointers with optional auto-increment, and returns read data through a valid/ready handshake with overrun reporting. Successor to the fixed 256x8 command RAM, generalised in depth, width and mode.

## Interface
- ADDR_WIDTH, 8, address bits; memory depth is 2**ADDR_WIDTH; must be <= DATA_WIDTH
- DATA_WIDTH, 8, memory word width and command payload width
- AUTO_INC, 1, 1 = pointer post-increments after each data write / read request; 0 = pointers static
- clk  input  1  clock, all state on rising edge
- rstn  input  1  reset, asynchronous, active-low
- rx_valid  input  1  command word valid for this cycle (single-cycle strobe per word)
- rx_data  input  DATA_WIDTH+2  [DATA_WIDTH+1:DATA_WIDTH] opcode, [DATA_WIDTH-1:0] payload
- tx_ready  input  1  downstream (SPI slave shifter) accepts tx_data this cycle
- tx_valid  output  1  tx_data holds read data
- tx_data  output  DATA_WIDTH  read data
- rd_err  output  1  one-cycle pulse: read request dropped (overrun)

## Operation
- Opcodes: 00 SET_WADDR (waddr <= payload[ADDR_WIDTH-1:0]); 01 WRITE (mem[waddr] <= payload; waddr++ if AUTO_INC); 10 SET_RADDR (raddr <= payload[ADDR_WIDTH-1:0]); 11 READ (payload ignored; fetch mem[raddr]; raddr++ if AUTO_INC).
- Commands are decoded only when rx_valid=1; otherwise nothing changes.
- Pointer arithmetic is modulo 2**ADDR_WIDTH: an increment from the top address wraps to 0.
- Payload bits above ADDR_WIDTH are ignored on SET_WADDR/SET_RADDR.
- Read FSM states:
  - IDLE: tx_valid=0. READ -> FETCH.
  - FETCH: one cycle; memory is read at raddr as captured at accept time. Loads tx_data, sets tx_valid -> HOLD.
  - HOLD: tx_valid=1 and tx_data stable until tx_ready=1 is sampled.
    - tx_ready=1 with no READ -> IDLE.
    - tx_ready=1 with simultaneous READ -> accept it -> FETCH.
- Overrun:
  - A READ in FETCH, or in HOLD with tx_ready=0, is dropped: raddr unchanged, rd_err=1 for one cycle.
  - SET_*/WRITE commands are always accepted in every state.
- Write-then-read of the same address on consecutive accepted commands returns the new data.
- Memory contents are not reset; reads of unwritten locations return X in simulation (bench must not check them).

## Timing
- Reset values: tx_valid=0, tx_data=0, rd_err=0, waddr=0, raddr=0, state=IDLE.
- Reset asserted mid-operation discards any pending read and clears the outputs immediately (asynchronous).
- WRITE accepted at edge N: memory updated at edge N; waddr+1 visible after edge N.
- READ accepted at edge N: FETCH during cycle N..N+1; tx_valid=1 with data after edge N+1 (latency 1 cycle).
- Handshake completes at the first edge where tx_valid=1 and tx_ready=1; tx_valid falls after that edge unless a READ was accepted at that same edge, in which case tx_valid drops for exactly one cycle (FETCH).
- rd_err asserts after the edge that sampled the dropped READ and clears after the next edge.
- Single memory port: the port address is waddr for a WRITE, otherwise the latched read address. WRITE and FETCH cannot collide because FETCH uses a registered read address and write-enable takes priority; a WRITE during FETCH stalls nothing and leaves the read data unaffected unless it targets the same address, in which case the new data is returned.

## Structure
- Package spi_ram_pkg: opcode constants (OP_SET_WADDR, OP_WRITE, OP_SET_RADDR, OP_READ) and the read FSM state enum (IDLE, FETCH, HOLD).
- Sub-module sp_ram: synchronous single-port RAM parametrised by ADDR_WIDTH/DATA_WIDTH, with inputs we/addr/din and a registered dout. The top level contains the decoder, pointers and FSM.

## Test plan
- After reset: SET_WADDR 0x10, WRITE 0xA5, SET_RADDR 0x10, READ with tx_ready=1 -> tx_valid rises 1 cycle after the READ edge with tx_data=0xA5; handshake completes in 1 cycle.
- AUTO_INC=1: SET_WADDR 0xFE, WRITE 0x11, 0x22, 0x33 -> addresses 0xFE, 0xFF, 0x00 hold 0x11, 0x22, 0x33; three READs from 0xFE return them in order, and raddr wraps to 0x01.
- AUTO_INC=0: two WRITEs (0x01 then 0x02) to address 0x05 -> READ at 0x05 returns 0x02; repeated READs return 0x02.
- Backpressure: hold tx_ready=0, issue READ, then a second READ while in HOLD -> rd_err pulses once, tx_data stays at the first value, raddr advanced only once.
- Back-to-back: in HOLD, tx_ready=1 on the same edge as a new READ -> first word is consumed, tx_valid=0 for one cycle, then the next word is presented.
- Reset mid-HOLD: deassert rstn while tx_valid=1 -> tx_valid=0 and tx_data=0 immediately; after release, SET_RADDR + READ behave normally and the memory retains its contents.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared definitions for the SPI command RAM.
//   OP_*        2-bit command opcodes carried in rx_data[DATA_WIDTH+1:DATA_WIDTH]
//   rd_state_e  read-path FSM states
package spi_ram_pkg;

  localparam logic [1:0] OP_SET_WADDR = 2'b00;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [1:0] OP_SET_RADDR = 2'b10;
  localparam logic [1:0] OP_READ      = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sp_ram.sv
// sp_ram: synchronous single-port RAM with registered read data.
//   clk   clock
//   we    write enable (mem[addr] <= din)
//   addr  port address, shared by read and write
//   din   write data
//   dout  registered read data of mem[addr]; holds its value on write cycles
//         so a write does not disturb a read already in flight
module sp_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    else    dout      <= mem[addr];
  end

endmodule

// File: rtl/spi_cmd_ram.sv
// spi_cmd_ram: command-decoding RAM behind the SPI slave word interface.
//   clk, rstn  clock / async active-low reset
//   rx_valid   command word strobe
//   rx_data    {opcode[1:0], payload[DATA_WIDTH-1:0]}
//   tx_ready   downstream accepts tx_data this cycle
//   tx_valid   tx_data holds read data
//   tx_data    read data, stable while tx_valid and not accepted
//   rd_err     one-cycle pulse when a READ is dropped (overrun)
module spi_cmd_ram
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AUTO_INC   = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH+1:0] rx_data,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  rd_err
);

  localparam logic [ADDR_WIDTH-1:0] INC = (AUTO_INC != 0) ? ADDR_WIDTH'(1) : '0;

  rd_state_e             state;
  logic [ADDR_WIDTH-1:0] waddr, raddr, rd_addr_q, ram_addr;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] payload;
  logic                  wr_cmd, rd_cmd, rd_acc, fetch_bypass;

  assign op      = rx_data[DATA_WIDTH+1:DATA_WIDTH];
  assign payload = rx_data[DATA_WIDTH-1:0];

  always_comb begin
    wr_cmd = rx_valid && (op == OP_WRITE);
    rd_cmd = rx_valid && (op == OP_READ);
    // A READ is taken only when the output slot is free or being drained now.
    rd_acc = rd_cmd && ((state == IDLE) || ((state == HOLD) && tx_ready));
    // Write owns the port; an accepted READ reads raddr directly so dout is
    // valid one edge later; otherwise keep pointing at the latched address.
    if (wr_cmd)      ram_addr = waddr;
    else if (rd_acc) ram_addr = raddr;
    else             ram_addr = rd_addr_q;
    // Same-address write during FETCH: dout was captured before the write,
    // so forward the fresh payload instead.
    fetch_bypass = (state == FETCH) && wr_cmd && (waddr == rd_addr_q);
  end

  sp_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk  (clk),
    .we   (wr_cmd),
    .addr (ram_addr),
    .din  (payload),
    .dout (ram_dout)
  );

  // Pointers; SET_* and WRITE are accepted in every read state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      waddr <= '0;
      raddr <= '0;
    end else if (rx_valid) begin
      case (op)
        OP_SET_WADDR: waddr <= payload[ADDR_WIDTH-1:0];
        OP_WRITE:     waddr <= waddr + INC;
        OP_SET_RADDR: raddr <= payload[ADDR_WIDTH-1:0];
        default:      if (rd_acc) raddr <= raddr + INC;
      endcase
    end
  end

  // Read FSM with registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      rd_addr_q <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      rd_err    <= 1'b0;
    end else begin
      rd_err <= rd_cmd && !rd_acc;
      if (rd_acc) rd_addr_q <= raddr;
      case (state)
        IDLE: if (rd_acc) state <= FETCH;
        FETCH: begin
          tx_data  <= fetch_bypass ? payload : ram_dout;
          tx_valid <= 1'b1;
          state    <= HOLD;
        end
        HOLD: if (tx_ready) begin
          tx_valid <= 1'b0;
          state    <= rd_acc ? FETCH : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_ram.sv
// tb_spi_cmd_ram: two DUTs (AUTO_INC=0 and AUTO_INC=1) share one stimulus
// stream; a behavioural model per DUT (memory array, pointers, one pending
// fetch and one output slot) is compared against both every cycle, plus
// directed literal expectations for the main scenarios.
module tb_spi_cmd_ram;

  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            rx_valid = 1'b0;
  logic [DW+1:0]   rx_data = '0;
  logic            tx_ready = 1'b0;
  logic [1:0]      tx_valid, rd_err;
  logic [1:0][DW-1:0] tx_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_cmd_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AUTO_INC(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
    .rd_err(rd_err[0]));

  spi_cmd_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AUTO_INC(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
    .rd_err(rd_err[1]));

  // ---------------- behavioural model (index k = AUTO_INC value) ----------
  logic [7:0] m_mem   [2][256];
  bit         m_known [2][256];
  bit         m_valid[2], m_fetch[2], m_err[2], m_dknown[2];
  logic [7:0] m_data[2], m_waddr[2], m_raddr[2], m_faddr[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0; m_fetch[k] = 0; m_err[k] = 0;
      m_data[k] = '0; m_dknown[k] = 1;
      m_waddr[k] = '0; m_raddr[k] = '0; m_faddr[k] = '0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else begin
        for (int k = 0; k < 2; k++) begin
          logic [1:0] op;
          logic [7:0] pl;
          bit can, was_fetch;
          op = rx_data[DW+1:DW];
          pl = rx_data[DW-1:0];
          can = !m_fetch[k] && (!m_valid[k] || tx_ready);
          // a write lands first so a fetch of the same address sees it
          if (rx_valid && op == 2'b01) begin
            m_mem[k][m_waddr[k]] = pl;
            m_known[k][m_waddr[k]] = 1;
            m_waddr[k] = m_waddr[k] + 8'(k);
          end
          was_fetch = m_fetch[k];
          m_fetch[k] = 0;
          if (was_fetch) begin
            m_valid[k]  = 1;
            m_data[k]   = m_mem[k][m_faddr[k]];
            m_dknown[k] = m_known[k][m_faddr[k]];
          end else if (m_valid[k] && tx_ready) m_valid[k] = 0;
          m_err[k] = 0;
          if (rx_valid && op == 2'b11) begin
            if (can) begin
              m_fetch[k] = 1;
              m_faddr[k] = m_raddr[k];
              m_raddr[k] = m_raddr[k] + 8'(k);
            end else m_err[k] = 1;
          end
          if (rx_valid && op == 2'b00) m_waddr[k] = pl;
          if (rx_valid && op == 2'b10) m_raddr[k] = pl;
        end
      end
    end
  end

  task automatic check(input string name, input int k,
                       input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("model tx_valid", k, 8'(tx_valid[k]), 8'(m_valid[k]));
      check("model rd_err", k, 8'(rd_err[k]), 8'(m_err[k]));
      if (m_dknown[k]) check("model tx_data", k, tx_data[k], m_data[k]);
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge; presents one command for exactly one cycle and
  // returns at the falling edge after the rising edge that sampled it.
  task automatic cmd(input logic [1:0] op, input logic [7:0] pl);
    #2 rx_valid = 1'b1;
    rx_data = {op, pl};
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] wexp [4];
    wexp = '{8'h11, 8'h22, 8'h33, 8'h44};

    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    check("reset tx_valid", 1, 8'(tx_valid[1]), 8'h00);
    check("reset tx_data", 1, tx_data[1], 8'h00);

    // basic write / read with a ready sink
    tx_ready = 1'b1;
    cmd(2'b00, 8'h10); cmd(2'b01, 8'hA5); cmd(2'b10, 8'h10); cmd(2'b11, 8'h00);
    check("fetch cycle tx_valid", 1, 8'(tx_valid[1]), 8'h00);
    @(negedge clk);
    check("first read valid", 1, 8'(tx_valid[1]), 8'h01);
    check("first read data", 1, tx_data[1], 8'hA5);
    @(negedge clk);
    check("handshake done", 1, 8'(tx_valid[1]), 8'h00);

    // wrap with auto-increment; dut0 keeps overwriting 0xFE
    cmd(2'b00, 8'hFE);
    for (int i = 0; i < 4; i++) cmd(2'b01, wexp[i]);
    cmd(2'b10, 8'hFE);
    for (int i = 0; i < 4; i++) begin
      cmd(2'b11, 8'h00);
      @(negedge clk);
      check("wrap read", 1, tx_data[1], wexp[i]);
      check("static read", 0, tx_data[0], 8'h44);
    end
    @(negedge clk);

    // backpressure: second READ in HOLD is dropped
    tx_ready = 1'b0;
    cmd(2'b10, 8'hFE); cmd(2'b11, 8'h00);
    @(negedge clk);
    cmd(2'b11, 8'h00);
    check("overrun rd_err", 1, 8'(rd_err[1]), 8'h01);
    check("overrun data held", 1, tx_data[1], 8'h11);
    @(negedge clk);
    check("rd_err one cycle", 1, 8'(rd_err[1]), 8'h00);
    tx_ready = 1'b1;
    @(negedge clk);
    cmd(2'b11, 8'h00);
    @(negedge clk);
    check("raddr advanced once", 1, tx_data[1], 8'h22);
    @(negedge clk);

    // back-to-back: ready and a new READ on the same edge
    tx_ready = 1'b0;
    cmd(2'b10, 8'hFE); cmd(2'b11, 8'h00);
    @(negedge clk);
    tx_ready = 1'b1;
    cmd(2'b11, 8'h00);
    check("b2b gap", 1, 8'(tx_valid[1]), 8'h00);
    @(negedge clk);
    check("b2b valid", 1, 8'(tx_valid[1]), 8'h01);
    check("b2b data", 1, tx_data[1], 8'h22);
    @(negedge clk);

    // asynchronous reset while holding data
    tx_ready = 1'b0;
    cmd(2'b10, 8'h00); cmd(2'b11, 8'h00);
    @(negedge clk);
    check("pre-reset valid", 1, 8'(tx_valid[1]), 8'h01);
    #2 rstn = 1'b0;
    #1;
    check("async reset tx_valid", 1, 8'(tx_valid[1]), 8'h00);
    check("async reset tx_data", 1, tx_data[1], 8'h00);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    tx_ready = 1'b1;
    cmd(2'b10, 8'h10); cmd(2'b11, 8'h00);
    @(negedge clk);
    check("memory retained", 1, tx_data[1], 8'hA5);
    check("memory retained", 0, tx_data[0], 8'hA5);
    @(negedge clk);

    // randomized traffic, addresses clustered around the wrap point
    repeat (3000) begin
      logic [1:0] op;
      logic [7:0] pl;
      tx_ready = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      pl = (op == 2'b01) ? 8'($urandom) : 8'($urandom_range(0, 15) + 252);
      if ($urandom_range(0, 299) == 0) begin
        #2 rstn = 1'b0;
        #1 rstn = 1'b1;
        @(negedge clk);
      end else if ($urandom_range(0, 3) != 0) cmd(op, pl);
      else @(negedge clk);
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
